agc_level_ctrl: RTL and testbench

- Digital automatic-gain-control loop that sits directly downstream of the tuned selective amplifier.
- Consumes signed ADC samples of the amplifier output node and tracks the peak absolute amplitude over a fixed window.
- Once per window, steps a gain code that drives the amplifier's bias/gain trim.
- After any gain change, waits a settle interval so the LC tank's ringing does not corrupt the next measurement.

---
 rtl/agc_level_ctrl.sv | 179 +++++++++++++++++
 tb/tb_agc_level_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_level_ctrl.sv
`default_nettype none
// ============================================================================
// agc_level_ctrl : windowed peak-detect AGC stepping the amplifier gain code
// Optional macro AGC_FAST_ATTACK_EN : full-scale sample aborts the window.
// Revision 1.0
// ============================================================================
module agc_level_ctrl #(
  parameter int DW        = 12,
  parameter int WIN_LOG2  = 8,
  parameter int GW        = 6,
  parameter int TARGET    = 1024,
  parameter int HYST      = 128,
  parameter int SETTLE    = 64,
  parameter int GAIN_INIT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [GW-1:0] gain_code,
  output logic          gain_valid,
  output logic [DW-2:0] peak,
  output logic          overload,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [DW-1:0]       FS_POS    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]       FS_NEG    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW:0]         TH_HI     = (DW+1)'(TARGET + HYST);
  localparam logic [DW:0]         TH_LO     = (HYST > TARGET) ? '0 : (DW+1)'(TARGET - HYST);
`ifdef AGC_FAST_ATTACK_EN
  localparam logic [GW:0]         OV_STEP   = (GW+1)'(4);
  localparam logic                FAST_ATK  = 1'b1;
`else
  localparam logic [GW:0]         OV_STEP   = (GW+1)'(2);
  localparam logic                FAST_ATK  = 1'b0;
`endif
  localparam logic [GW:0]         GAIN_MAX  = {1'b0, {GW{1'b1}}};
  localparam logic [GW-1:0]       GAIN_RST  = GW'(GAIN_INIT);
  localparam logic [GW-1:0]       GAIN_ONE  = GW'(1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(SETTLE - 1);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST  = '1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE   = WIN_LOG2'(1);

  logic [1:0]          state;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [DW-2:0]       run_peak;
  logic                win_ovl;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                accept;
  logic                full_scale;
  logic [DW-1:0]       neg_data;
  logic [DW-2:0]       mag;
  logic [DW-2:0]       peak_upd;
  logic                win_done;
  logic [GW:0]         gain_ext;
  logic [GW-1:0]       gain_next;
  logic                gain_chg;

  assign s_ready    = (state != ST_UPDATE);
  assign gain_valid = (state == ST_UPDATE);
  assign busy       = (state != ST_IDLE);
  assign accept     = s_valid && s_ready;

  // Saturating magnitude: the most negative code has no positive twin.
  assign neg_data   = -s_data;
  assign full_scale = (s_data == FS_POS) || (s_data == FS_NEG);

  always_comb begin
    mag = s_data[DW-2:0];
    if (s_data == FS_NEG) begin
      mag = FS_POS[DW-2:0];
    end else if (s_data[DW-1]) begin
      mag = neg_data[DW-2:0];
    end
  end

  assign peak_upd = (mag > run_peak) ? mag : run_peak;
  assign win_done = (win_cnt == WIN_LAST) || (FAST_ATK && full_scale);

  // Gain step decided from the completed window's peak and overload flag.
  always_comb begin
    gain_ext  = {1'b0, gain_code};
    gain_next = gain_code;
    if (win_ovl) begin
      gain_next = (gain_ext >= OV_STEP) ? GW'(gain_ext - OV_STEP) : '0;
    end else if ({2'b00, run_peak} > TH_HI) begin
      gain_next = (gain_code != '0) ? (gain_code - GAIN_ONE) : '0;
    end else if ({2'b00, run_peak} < TH_LO) begin
      gain_next = (gain_ext < GAIN_MAX) ? (gain_code + GAIN_ONE) : gain_code;
    end
  end

  assign gain_chg = (gain_next != gain_code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gain_code <= GAIN_RST;
      peak      <= '0;
      overload  <= 1'b0;
      win_cnt   <= '0;
      run_peak  <= '0;
      win_ovl   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      // A completed window is always committed, even if enable drops now.
      if (state == ST_UPDATE) begin
        peak      <= run_peak;
        overload  <= win_ovl;
        gain_code <= gain_next;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_ACQ;
            win_cnt  <= '0;
            run_peak <= '0;
            win_ovl  <= 1'b0;
          end
        end
        ST_ACQ: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (accept) begin
            run_peak <= peak_upd;
            win_ovl  <= win_ovl | full_scale;
            win_cnt  <= win_cnt + WIN_ONE;
            if (win_done) begin
              state <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (gain_chg) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end else begin
            state    <= ST_ACQ;
            win_cnt  <= '0;
            run_peak <= '0;
            win_ovl  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_ACQ;
            win_cnt  <= '0;
            run_peak <= '0;
            win_ovl  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agc_level_ctrl.sv
`default_nettype none
// tb_agc_level_ctrl : drives whole measurement windows and checks each update
// against a window-level model of the AGC gain rule and settle timing.
module tb_agc_level_ctrl;

  localparam int DW        = 12;
  localparam int WIN_LOG2  = 4;
  localparam int GW        = 6;
  localparam int TARGET    = 1024;
  localparam int HYST      = 128;
  localparam int SETTLE    = 64;
  localparam int GAIN_INIT = 32;
  localparam int WIN       = 1 << WIN_LOG2;
  localparam int FS        = (1 << (DW-1)) - 1;
  localparam int GMAX      = (1 << GW) - 1;
`ifdef AGC_FAST_ATTACK_EN
  localparam int OV_STEP   = 4;
  localparam bit FAST      = 1'b1;
`else
  localparam int OV_STEP   = 2;
  localparam bit FAST      = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [GW-1:0] gain_code;
  logic          gain_valid;
  logic [DW-2:0] peak;
  logic          overload;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_gain;
  int exp_peak;
  int exp_ovl;

  always #5 clk = ~clk;

  agc_level_ctrl #(
    .DW(DW), .WIN_LOG2(WIN_LOG2), .GW(GW), .TARGET(TARGET),
    .HYST(HYST), .SETTLE(SETTLE), .GAIN_INIT(GAIN_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .gain_code(gain_code),
    .gain_valid(gain_valid), .peak(peak), .overload(overload), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mag_of(input int s);
    if (s < -FS) return FS;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int gain_rule(input int g, input int pk, input bit ov);
    int lo;
    lo = (HYST > TARGET) ? 0 : TARGET - HYST;
    if (ov)                return (g >= OV_STEP) ? g - OV_STEP : 0;
    if (pk > TARGET + HYST) return (g > 0) ? g - 1 : 0;
    if (pk < lo)           return (g < GMAX) ? g + 1 : GMAX;
    return g;
  endfunction

  function automatic int make_sample(input int m);
    if (m > FS) return -(FS + 1);
    return ($urandom_range(1, 0) == 1) ? m : -m;
  endfunction

  // Feeds one window (DUT must be in ACQ), checks the update cycle and result,
  // then covers the settle interval with full-scale junk that must be dropped.
  task automatic run_window(input int samp[$], input int gap_max, input bit skip_hold);
    int  pk;
    bit  ov;
    bit  fs;
    bit  last;
    int  g_new;
    pk = 0;
    ov = 1'b0;
    for (int i = 0; i < samp.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        s_valid = 1'b0;
        tick();
        check("no_pulse_gap", int'(gain_valid), 0);
      end
      s_valid = 1'b1;
      s_data  = DW'(samp[i]);
      tick();
      fs   = (samp[i] == FS) || (samp[i] == -(FS + 1));
      pk   = (mag_of(samp[i]) > pk) ? mag_of(samp[i]) : pk;
      ov   = ov | fs;
      last = (i == samp.size() - 1) || (FAST && fs);
      if (last) break;
      check("no_pulse_mid", int'(gain_valid), 0);
    end
    s_valid = 1'b0;
    check("pulse", int'(gain_valid), 1);
    check("ready_upd", int'(s_ready), 0);
    g_new = gain_rule(exp_gain, pk, ov);
    tick();
    exp_peak = pk;
    exp_ovl  = int'(ov);
    check("peak", int'(peak), exp_peak);
    check("overload", int'(overload), exp_ovl);
    check("gain", int'(gain_code), g_new);
    check("pulse_end", int'(gain_valid), 0);
    if (g_new != exp_gain && !skip_hold) begin
      repeat (SETTLE) begin
        s_valid = 1'b1;
        s_data  = DW'(-(FS + 1));
        tick();
      end
      s_valid = 1'b0;
    end
    exp_gain = g_new;
  endtask

  initial begin
    int q[$];
    int m;
    int fs_pos;
    int guard;

    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    exp_gain = GAIN_INIT; exp_peak = 0; exp_ovl = 0;
    repeat (2) tick();
    check("rst_gain", int'(gain_code), GAIN_INIT);
    check("rst_peak", int'(peak), 0);
    check("rst_ovl", int'(overload), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_pulse", int'(gain_valid), 0);

    // Disabled: samples are swallowed, no update ever happens.
    rst_n = 1'b1;
    repeat (20) begin
      s_valid = 1'b1;
      s_data  = DW'(make_sample($urandom_range(FS, 0)));
      tick();
      check("idle_pulse", int'(gain_valid), 0);
    end
    check("idle_busy", int'(busy), 0);

    enable = 1'b1; s_valid = 1'b0;
    tick();
    check("acq_busy", int'(busy), 1);

    q = {};
    for (int i = 0; i < WIN; i++) q.push_back((i % 2 == 0) ? 300 : -300);
    run_window(q, 0, 1'b0);
    check("small_gain", exp_gain, GAIN_INIT + 1);

    q = {};
    for (int i = 0; i < WIN; i++) q.push_back(make_sample(1100));
    run_window(q, 0, 1'b0);

    q = {};
    fs_pos = $urandom_range(WIN - 1, 0);
    for (int i = 0; i < WIN; i++) q.push_back((i == fs_pos) ? -(FS + 1) : make_sample(500));
    run_window(q, 1, 1'b0);
    check("ovl_gain", exp_gain, GAIN_INIT + 1 - OV_STEP);

    // Drop enable mid-window; the partial window must not count.
    for (int i = 0; i < WIN / 2; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(make_sample(2000));
      tick();
    end
    enable = 1'b0; s_valid = 1'b0;
    tick();
    check("drop_busy", int'(busy), 0);
    repeat (5) begin
      s_valid = 1'b1;
      s_data  = DW'(make_sample(1500));
      tick();
      check("drop_pulse", int'(gain_valid), 0);
    end
    check("drop_gain", int'(gain_code), exp_gain);
    check("drop_peak", int'(peak), exp_peak);
    enable = 1'b1; s_valid = 1'b0;
    tick();
    q = {};
    for (int i = 0; i < WIN; i++) q.push_back(make_sample(200));
    run_window(q, 1, 1'b0);

    // Randomized windows across all gain-rule regions.
    repeat (30) begin
      q = {};
      fs_pos = ($urandom_range(3, 0) == 0) ? int'($urandom_range(WIN - 1, 0)) : -1;
      case ($urandom_range(3, 0))
        0:       m = 700;
        1:       m = 1150;
        2:       m = 2046;
        default: m = FS;
      endcase
      for (int i = 0; i < WIN; i++) begin
        if (i == fs_pos)
          q.push_back(($urandom_range(1, 0) == 1) ? FS : -(FS + 1));
        else if (m == 1150)
          q.push_back(make_sample($urandom_range(1150, 900)));
        else if (m == 2046)
          q.push_back(make_sample($urandom_range(2046, 1200)));
        else
          q.push_back(make_sample($urandom_range(m, 0)));
      end
      run_window(q, 2, 1'b0);
    end

    // Clamp at zero, then at the top.
    guard = 0;
    while ((exp_gain > 0 || guard < 2) && guard < 80) begin
      if (exp_gain == 0) guard++;
      q = {};
      for (int i = 0; i < WIN; i++) q.push_back(make_sample(2000));
      run_window(q, 0, 1'b0);
    end
    check("clamp_lo", int'(gain_code), 0);
    guard = 0;
    while ((exp_gain < GMAX || guard < 2) && guard < 80) begin
      if (exp_gain == GMAX) guard++;
      q = {};
      for (int i = 0; i < WIN; i++) q.push_back(make_sample(10));
      run_window(q, 0, 1'b0);
    end
    check("clamp_hi", int'(gain_code), GMAX);

    // Reset in the middle of a settle interval.
    q = {};
    for (int i = 0; i < WIN; i++) q.push_back(make_sample(2000));
    run_window(q, 0, 1'b1);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check("hrst_gain", int'(gain_code), GAIN_INIT);
    check("hrst_peak", int'(peak), 0);
    check("hrst_ovl", int'(overload), 0);
    check("hrst_busy", int'(busy), 0);
    check("hrst_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    tick();
    exp_gain = GAIN_INIT;
    q = {};
    for (int i = 0; i < WIN; i++) q.push_back(make_sample(1000));
    run_window(q, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
